// File: rtl/fastest_finger_first.sv
// Two-contestant buzzer lockout. The first synchronised rising edge wins and latches until reset.
// Optional feature macro: FFF_TIE_PRIORITY_EN gives contestant 1 priority on a same-cycle press.
module fastest_finger_first #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buzzer_user1,
  input  logic       buzzer_user2,
  output logic       winner_user1,
  output logic       winner_user2,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WIN1 = 2'b01,
    WIN2 = 2'b10,
    TIE  = 2'b11
  } state_t;

  state_t     state_q;
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] prev_q;
  logic [1:0] press_d;

  // Bit 0 tracks contestant 1, bit 1 contestant 2. Reset loads "pressed" so a
  // button held through reset release must be released and pressed again.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b11;
      prev_q <= 2'b11;
    end else begin
      sync_q[0] <= {buzzer_user2, buzzer_user1};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_d = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          case (press_d)
            2'b01:   state_q <= WIN1;
            2'b10:   state_q <= WIN2;
`ifdef FFF_TIE_PRIORITY_EN
            2'b11:   state_q <= WIN1;
`else
            2'b11:   state_q <= TIE;
`endif
            default: state_q <= IDLE;
          endcase
        end
        default: state_q <= state_q;
      endcase
    end
  end

  // Decisions are terminal, so outputs depend on the state register only.
  assign winner_user1 = (state_q == WIN1);
  assign winner_user2 = (state_q == WIN2);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fastest_finger_first.sv
// Bench for fastest_finger_first: directed scenarios plus randomized button activity
// compared every cycle against a sample-history model of the lockout rules.
module tb_fastest_finger_first;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       buzzer_user1 = 1'b0;
  logic       buzzer_user2 = 1'b0;
  logic       winner_user1;
  logic       winner_user2;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // Clock/reset block.
  always #5 clk = ~clk;

  fastest_finger_first #(.SYNC_STAGES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .buzzer_user1 (buzzer_user1),
    .buzzer_user2 (buzzer_user2),
    .winner_user1 (winner_user1),
    .winner_user2 (winner_user2),
    .dbg_state_o  (dbg_state)
  );

  // Reference model. Each button's samples at clock edges are kept newest first;
  // a reset edge counts as "pressed" for the whole history. A press is seen at
  // edge k when the sample taken S edges earlier is high and the one before it low.
  bit h1 [S+1];
  bit h2 [S+1];
  int win = 0;  // 0 none, 1 contestant 1, 2 contestant 2, 3 tie

  always @(posedge clk) begin
    bit p1, p2;
    if (!rst) begin
      win = 0;
      for (int i = 0; i <= S; i++) begin h1[i] = 1'b1; h2[i] = 1'b1; end
    end else begin
      p1 = h1[S-1] && !h1[S];
      p2 = h2[S-1] && !h2[S];
      if (win == 0) begin
        if (p1 && !p2) win = 1;
        else if (p2 && !p1) win = 2;
        else if (p1 && p2) begin
`ifdef FFF_TIE_PRIORITY_EN
          win = 1;
`else
          win = 3;
`endif
        end
      end
      for (int i = S; i > 0; i--) begin h1[i] = h1[i-1]; h2[i] = h2[i-1]; end
      h1[0] = buzzer_user1;
      h2[0] = buzzer_user2;
    end
  end

  task automatic check_model(input string tag);
    logic e1, e2;
    e1 = (win == 1);
    e2 = (win == 2);
    checks++;
    assert (winner_user1 === e1) else begin
      failures++;
      $error("FAIL %s winner_user1 observed=%b expected=%b", tag, winner_user1, e1);
    end
    checks++;
    assert (winner_user2 === e2) else begin
      failures++;
      $error("FAIL %s winner_user2 observed=%b expected=%b", tag, winner_user2, e2);
    end
  endtask

  task automatic expect_out(input string tag, input logic e1, input logic e2);
    checks++;
    assert ({winner_user1, winner_user2} === {e1, e2}) else begin
      failures++;
      $error("FAIL %s outputs observed=%b%b expected=%b%b", tag, winner_user1, winner_user2, e1, e2);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs are checked just after the rising edge.
  task automatic step(input logic b1, input logic b2, input logic r, input string tag);
    @(negedge clk);
    buzzer_user1 = b1;
    buzzer_user2 = b2;
    rst = r;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic steps(input int n, input logic b1, input logic b2, input logic r, input string tag);
    for (int i = 0; i < n; i++) step(b1, b2, r, tag);
  endtask

  initial begin
    logic b1, b2, r;

    // Reset then quiet.
    steps(2, 0, 0, 0, "reset");
    expect_out("reset_state", 0, 0);
    steps(20, 0, 0, 1, "idle");
    expect_out("idle_20", 0, 0);

    // user1 pulse, then user2 pulse 5 cycles later; exact latency checked.
    step(1, 0, 1, "u1_edgeN");
    for (int i = 1; i < S; i++) begin
      expect_out("u1_before_latency", 0, 0);
      step(1, 0, 1, "u1_pulse");
    end
    expect_out("u1_before_latency", 0, 0);
    step((S < 3) ? 1'b1 : 1'b0, 0, 1, "u1_latency_edge");
    expect_out("u1_at_latency", 1, 0);
    steps((S < 3) ? 3 - S - 1 : 0, 1, 0, 1, "u1_pulse_tail");
    steps(5, 0, 0, 1, "gap");
    steps(3, 0, 1, 1, "u2_late");
    steps(10, 0, 0, 1, "hold");
    expect_out("u1_holds", 1, 0);

    // Reset, user2 then user1.
    steps(2, 0, 0, 0, "reset2");
    steps(2, 0, 0, 1, "quiet2");
    steps(3, 0, 1, 1, "u2_first");
    steps(3, 1, 0, 1, "u1_second");
    steps(4, 0, 0, 1, "settle2");
    expect_out("u2_wins", 0, 1);
    step(0, 0, 0, "reset_first_edge");
    expect_out("reset_clears", 0, 0);

    // Simultaneous press.
    steps(2, 0, 0, 1, "quiet3");
    steps(3, 1, 1, 1, "both");
    steps(4, 0, 0, 1, "settle3");
`ifdef FFF_TIE_PRIORITY_EN
    expect_out("both_priority", 1, 0);
`else
    expect_out("both_tie", 0, 0);
`endif

    // user1 held across reset release.
    steps(2, 1, 0, 0, "held_reset");
    steps(6, 1, 0, 1, "held_after");
    expect_out("held_no_win", 0, 0);
    steps(2, 0, 0, 1, "release");
    steps(3, 0, 1, 1, "u2_after_held");
    steps(4, 0, 0, 1, "settle4");
    expect_out("held_then_u2", 0, 1);

    // Reset on the edge where the press would register.
    steps(2, 0, 0, 0, "reset5");
    steps(2, 0, 0, 1, "quiet5");
    steps(S, 1, 0, 1, "u1_pre");
    step(1, 0, 0, "reset_on_decision");
    expect_out("reset_beats_press", 0, 0);
    steps(6, 0, 0, 1, "after5");
    expect_out("reset_beats_press_hold", 0, 0);

    // Randomized activity.
    b1 = 0; b2 = 0;
    for (int round = 0; round < 40; round++) begin
      steps($urandom_range(1, 2), b1, b2, 0, "rand_reset");
      for (int c = 0; c < $urandom_range(10, 40); c++) begin
        if ($urandom_range(0, 7) == 0) begin
          b1 = ~b1; b2 = b1;
        end else begin
          if ($urandom_range(0, 3) == 0) b1 = ~b1;
          if ($urandom_range(0, 3) == 0) b2 = ~b2;
        end
        r = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
        step(b1, b2, r, "random");
        checks++;
        assert (!(winner_user1 && winner_user2)) else begin
          failures++;
          $error("FAIL onehot observed=%b%b expected=not 11", winner_user1, winner_user2);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
